// File: rtl/seconds_display_pkg.sv
// rtl/seconds_display_pkg.sv - shared types, widths and segment patterns for seconds_display
package seconds_display_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int SEC_W = 10;
  localparam int BCD_W = 16;

  // Segment order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (bcd[k*4 +: 4] >= 4'd5) res[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to seven-segment decoder with blanking
module bcd_to_seg
  import seconds_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seconds_display.sv
// rtl/seconds_display.sv - binary seconds to 4-digit multiplexed seven-segment display
// Double-dabble conversion runs one bit per clock; results commit atomically to the display.
module seconds_display
  import seconds_display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 2500,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [SEC_W-1:0] seconds,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             busy,
  output logic             bcd_valid
);

  state_t           state;
  logic [SEC_W-1:0] bin_sr;
  logic [SEC_W-1:0] pend_val;
  logic             pending;
  logic [BCD_W-1:0] bcd_acc;
  logic [BCD_W-1:0] disp;
  logic [3:0]       iter;

  logic [BCD_W-1:0] bcd_next;
  logic [SEC_W-1:0] bin_next;
  logic [BCD_W-1:0] bcd_adj;

  logic [15:0]      refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic [6:0]       seg_sel;

  always_comb begin
    bcd_adj              = dabble_adjust(bcd_acc);
    {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bin_sr    <= '0;
      pend_val  <= '0;
      pending   <= 1'b0;
      bcd_acc   <= '0;
      disp      <= '0;
      iter      <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            bin_sr  <= seconds;
            bcd_acc <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_acc <= bcd_next;
          bin_sr  <= bin_next;
          iter    <= iter + 4'd1;
          if (tick) begin
            pending  <= 1'b1;
            pend_val <= seconds;
          end
          if (iter == 4'(SEC_W - 1)) begin
            disp      <= bcd_next;
            bcd_valid <= 1'b1;
            // A tick on the final edge is the newest value and supersedes any pending one.
            if (tick || pending) begin
              bin_sr  <= tick ? seconds : pend_val;
              bcd_acc <= '0;
              iter    <= '0;
              pending <= 1'b0;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cur_digit = disp[3:0];
    cur_blank = 1'b0;
    case (digit_idx)
      2'd0: cur_digit = disp[3:0];
      2'd1: begin
        cur_digit = disp[7:4];
        cur_blank = BLANK_LZ && (disp[15:4] == 12'd0);
      end
      2'd2: begin
        cur_digit = disp[11:8];
        cur_blank = BLANK_LZ && (disp[15:8] == 8'd0);
      end
      2'd3: begin
        cur_digit = disp[15:12];
        cur_blank = BLANK_LZ && (disp[15:12] == 4'd0);
      end
      default: cur_digit = disp[3:0];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      an          <= 4'b0001;
      seg         <= SEG_0;
    end else begin
      if (refresh_cnt == 16'(REFRESH_CYCLES - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 16'd1;
      end
      an  <= 4'b0001 << digit_idx;
      seg <= seg_sel;
    end
  end

endmodule

// File: tb/tb_seconds_display.sv
// tb/tb_seconds_display.sv - randomized scoreboard bench for seconds_display
module tb_seconds_display;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [9:0] seconds;
  logic [6:0] seg_b, seg_f;
  logic [3:0] an_b, an_f;
  logic       busy_b, busy_f, bv_b, bv_f;

  seconds_display #(.REFRESH_CYCLES(R), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst(rst), .tick(tick), .seconds(seconds),
    .seg(seg_b), .an(an_b), .busy(busy_b), .bcd_valid(bv_b)
  );

  seconds_display #(.REFRESH_CYCLES(R), .BLANK_LZ(1'b0)) u_full (
    .clk(clk), .rst(rst), .tick(tick), .seconds(seconds),
    .seg(seg_f), .an(an_f), .busy(busy_f), .bcd_valid(bv_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int edge_n;
  } exp_t;

  exp_t q_b[$];
  exp_t q_f[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   busy_end = 0;
  int   pend = 0;
  int   pval = 0;
  int   disp_b = 0;
  int   disp_f = 0;

  logic [6:0] seg_tbl [10];
  int         p10 [4];

  initial begin
    seg_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    p10     = '{1, 10, 100, 1000};
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int seg_exp(input int v, input int k, input bit blz);
    int d;
    d = (v / p10[k]) % 10;
    if (blz && k > 0 && v < p10[k]) return 0;
    return int'(seg_tbl[d]);
  endfunction

  function automatic int an_exp(input int n);
    if (n == 0) return 1;
    return 1 << (((n - 1) / R) % 4);
  endfunction

  // Reference model: a tick always becomes the newest candidate; it starts as soon as
  // the converter is free, and the result appears ten edges after the start.
  always @(posedge clk) begin : model
    int c, p, pv;
    if (!rst) begin
      q_b.delete();
      q_f.delete();
      edge_cnt <= 0;
      busy_end <= 0;
      pend     <= 0;
    end else begin
      c  = edge_cnt + 1;
      p  = pend;
      pv = pval;
      if (tick) begin
        p  = 1;
        pv = int'(seconds);
      end
      if (c >= busy_end && p != 0) begin
        q_b.push_back('{pv, c + 10});
        q_f.push_back('{pv, c + 10});
        busy_end <= c + 10;
        p = 0;
      end
      pend     <= p;
      pval     <= pv;
      edge_cnt <= c;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      disp_b = 0;
      disp_f = 0;
    end else begin
      check("busy_blank", int'(busy_b), int'(edge_cnt < busy_end));
      check("busy_full", int'(busy_f), int'(edge_cnt < busy_end));
      check("an_blank", int'(an_b), an_exp(edge_cnt));
      check("an_full", int'(an_f), an_exp(edge_cnt));
      check("seg_blank", int'(seg_b), seg_exp(disp_b, idx_of(an_b), 1'b1));
      check("seg_full", int'(seg_f), seg_exp(disp_f, idx_of(an_f), 1'b0));
      if (bv_b) begin
        check("bcd_valid_expected_blank", int'(q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check("bcd_valid_edge_blank", edge_cnt, e.edge_n);
          disp_b = e.val;
        end
      end
      if (bv_f) begin
        check("bcd_valid_expected_full", int'(q_f.size() > 0), 1);
        if (q_f.size() > 0) begin
          e = q_f.pop_front();
          check("bcd_valid_edge_full", edge_cnt, e.edge_n);
          disp_f = e.val;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int v);
    @(negedge clk);
    tick    = 1'b1;
    seconds = 10'(v);
    @(negedge clk);
    tick    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst  = 1'b0;
    tick = 1'b0;
    #1;
    check("rst_an_blank", int'(an_b), 1);
    check("rst_seg_blank", int'(seg_b), 7'b0111111);
    check("rst_busy_blank", int'(busy_b), 0);
    check("rst_bv_blank", int'(bv_b), 0);
    check("rst_an_full", int'(an_f), 1);
    check("rst_seg_full", int'(seg_f), 7'b0111111);
    check("rst_busy_full", int'(busy_f), 0);
    check("rst_bv_full", int'(bv_f), 0);
    idle(2);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    tick    = 1'b0;
    seconds = '0;
    idle(2);
    do_reset();
    idle(3);
    send(437);  idle(20);
    send(1023); idle(20);
    send(7);    idle(20);
    send(0);    idle(20);
    send(59);   idle(2);
    send(60);   idle(30);
    send(555);  idle(4);
    do_reset();
    idle(30);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        send(999);
        idle(5);
        do_reset();
      end
      if ($urandom_range(0, 4) == 0) begin
        send(int'($urandom_range(0, 1023)));
      end else begin
        idle(1);
      end
    end
    idle(40);
    check("drain_blank", q_b.size(), 0);
    check("drain_full", q_f.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
